mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
Multi-cycle successor to the single-cycle MIPS control unit. It is a Moore FSM that sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over several cycles. Memory accesses use a ready handshake with a wait-state timeout. Sits between the IR opcode field, the shared instruction/data memory, and the multi-cycle datapath muxes/enables.

Parameters:
MEM_HANDSHAKE, 1, 1: memory states hold until MemReady; 0: memory states last exactly one cycle, MemReady ignored
TIMEOUT, 15, max wait cycles in a memory state before error; 0 disables timeout
ENABLE_BNE, 1, 1: BNE decoded; 0: BNE treated as illegal
CW, 4, width of wait counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
OpCode  in  6  IR[31:26], stable from end of FETCH until next FETCH
MemReady  in  1  memory completes access this cycle
IorD  out  1  0: mem addr=PC, 1: mem addr=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load IR
PCWrite  out  1  unconditional PC load
Branch  out  1  PC load if Zero (BEQ)
BranchNe  out  1  PC load if !Zero (BNE)
RegDst  out  1  0: Rt, 1: Rd
MemtoReg  out  1  0: ALUOut, 1: MDR
RegWrite  out  1  register file write
ALUSrcA  out  1  0: PC, 1: A
ALUSrcB  out  2  00: B, 01: 4, 10: SignImm, 11: SignImm<<2
ALUOp  out  2  00 add, 01 sub, 10 funct, 11 opcode-decoded immediate op
PCSrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
IllegalOp  out  1  1-cycle pulse: unsupported opcode
MemError  out  1  1-cycle pulse: memory timeout
State  out  4  current state code (debug)

Behaviour:
- Async reset -> State=FETCH(0), wait counter=0. While reset is high, IRWrite, PCWrite, RegWrite, MemWrite, IllegalOp and MemError are forced 0. All outputs are functions of State (and MemReady for fetch strobes). Unlisted outputs are 0 in every state.
- States/codes and outputs:
  - FETCH 0: MemRead=1, ALUSrcB=01. IRWrite=PCWrite=1 only in the cycle MemReady=1 (or always, if MEM_HANDSHAKE=0).
  - DECODE 1: ALUSrcB=11.
  - MEMADR 2: ALUSrcA=1, ALUSrcB=10.
  - MEMRD 3: IorD=1, MemRead=1.
  - MEMWB 4: MemtoReg=1, RegWrite=1.
  - MEMWR 5: IorD=1, MemWrite=1 held until completion.
  - EXECUTE 6: ALUSrcA=1, ALUOp=10.
  - ALUWB 7: RegDst=1, RegWrite=1.
  - BRANCH 8: ALUSrcA=1, ALUOp=01, PCSrc=01. Branch=1 for BEQ, BranchNe=1 for BNE.
  - IMMEXEC 9: ALUSrcA=1, ALUSrcB=10. ALUOp=00 for ADDI, 11 for SLTI/ANDI/ORI/XORI.
  - IMMWB 10: RegWrite=1.
  - JUMP 11: PCSrc=10, PCWrite=1.
  - ERROR 12: IllegalOp or MemError (whichever caused entry) =1.
- Transitions:
  - FETCH->DECODE on completion.
  - DECODE decodes OpCode: 000000->EXECUTE; 100011/101011->MEMADR; 000100->BRANCH; 000101->BRANCH if ENABLE_BNE, else ERROR; 001000/001010/001100/001101/001110->IMMEXEC; 000010->JUMP; any other->ERROR(IllegalOp).
  - MEMADR->MEMRD (LW) / MEMWR (SW).
  - MEMRD->MEMWB on completion.
  - EXECUTE->ALUWB; IMMEXEC->IMMWB.
  - MEMWB, MEMWR (on completion), ALUWB, IMMWB, BRANCH, JUMP, ERROR->FETCH.
- Completion in memory states (FETCH, MEMRD, MEMWR): MemReady=1 sampled at the clock edge; immediate if MEM_HANDSHAKE=0.
- Wait counter: cleared on entry to any memory state. Increments each cycle in a memory state without MemReady. If counter==TIMEOUT-1 and MemReady=0 (TIMEOUT>0) -> ERROR with MemError. MemReady on that same cycle wins: normal completion, no error.
- Instruction cycle counts at zero wait: R/I-type 4, LW 5, SW 4, BEQ/BNE 3, J 3, illegal 3.
- Reset mid-instruction: immediate return to FETCH. No write strobe glitches high during reset.

Test Plan:
- MEM_HANDSHAKE=1, MemReady tied 1, OpCode=000000 -> States 0,1,6,7,0. RegWrite=1, RegDst=1 in state 7 only. IRWrite/PCWrite high 1 cycle in 0.
- LW with MemReady low 3 cycles in MEMRD, then high -> State holds 3 for 4 cycles, then 4 with MemtoReg=1, RegWrite=1. Total 8 cycles.
- TIMEOUT=15, MemReady stuck 0 in FETCH -> 15 cycles in state 0, then state 12 with MemError=1 one cycle. IRWrite never asserted. Then back to 0.
- MemReady rises exactly on the 15th wait cycle -> normal completion, MemError stays 0.
- ENABLE_BNE=0, OpCode=000101 -> 0,1,12 with IllegalOp=1, then 0. OpCode=111111 -> same. ENABLE_BNE=1 BNE -> state 8 with BranchNe=1, ALUOp=01, PCSrc=01.
- Assert reset while in MEMWR with MemWrite=1 -> MemWrite drops immediately (asynchronous), State=0. After release, fetch resumes normally. J opcode -> state 11 with PCWrite=1, PCSrc=10.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: a Moore FSM that sequences fetch/decode/execute/memory/writeback,
// with a MemReady handshake and a wait-state timeout on every memory access.
module mc_control_fsm #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int TIMEOUT       = 15,
  parameter int ENABLE_BNE    = 1,
  parameter int CW            = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       BranchNe,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       IllegalOp,
  output logic       MemError,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    IMMEXEC = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11,
    ERROR   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};

  state_t        state, stateNext;
  logic [CW-1:0] waitCnt;
  logic          errIsMem, errIsMemNext;
  logic          memState, memDone, timedOut;
  logic          irWriteRaw, pcWriteRaw, regWriteRaw, memWriteRaw, illegalRaw, memErrorRaw;

  assign memState = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign memDone  = (MEM_HANDSHAKE == 0) || MemReady;
  // A ready on the last allowed wait cycle still completes normally.
  assign timedOut = (MEM_HANDSHAKE != 0) && (TIMEOUT > 0) && memState && !MemReady
                    && (waitCnt == TO_LAST);

  // State, wait counter and error-cause register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      waitCnt  <= {CW{1'b0}};
      errIsMem <= 1'b0;
    end else begin
      state    <= stateNext;
      errIsMem <= errIsMemNext;
      if (stateNext != state) begin
        waitCnt <= {CW{1'b0}};
      end else if (memState && !MemReady) begin
        waitCnt <= waitCnt + CW'(1);
      end else begin
        waitCnt <= waitCnt;
      end
    end
  end

  // Next-state decode
  always_comb begin
    stateNext    = state;
    errIsMemNext = errIsMem;
    case (state)
      FETCH: begin
        if (timedOut) begin
          stateNext    = ERROR;
          errIsMemNext = 1'b1;
        end else if (memDone) begin
          stateNext = DECODE;
        end else begin
          stateNext = FETCH;
        end
      end
      DECODE: begin
        errIsMemNext = 1'b0;
        case (OpCode)
          OP_RTYPE:                                  stateNext = EXECUTE;
          OP_LW, OP_SW:                              stateNext = MEMADR;
          OP_BEQ:                                    stateNext = BRANCH;
          OP_BNE:                                    stateNext = (ENABLE_BNE != 0) ? BRANCH : ERROR;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: stateNext = IMMEXEC;
          OP_J:                                      stateNext = JUMP;
          default:                                   stateNext = ERROR;
        endcase
      end
      MEMADR: stateNext = (OpCode == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        if (timedOut) begin
          stateNext    = ERROR;
          errIsMemNext = 1'b1;
        end else if (memDone) begin
          stateNext = MEMWB;
        end else begin
          stateNext = MEMRD;
        end
      end
      MEMWR: begin
        if (timedOut) begin
          stateNext    = ERROR;
          errIsMemNext = 1'b1;
        end else if (memDone) begin
          stateNext = FETCH;
        end else begin
          stateNext = MEMWR;
        end
      end
      EXECUTE: stateNext = ALUWB;
      IMMEXEC: stateNext = IMMWB;
      default: stateNext = FETCH;
    endcase
  end

  // Moore output decode; write strobes are gated by reset below
  always_comb begin
    IorD        = 1'b0;
    MemRead     = 1'b0;
    memWriteRaw = 1'b0;
    irWriteRaw  = 1'b0;
    pcWriteRaw  = 1'b0;
    Branch      = 1'b0;
    BranchNe    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    regWriteRaw = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSrc       = 2'b00;
    illegalRaw  = 1'b0;
    memErrorRaw = 1'b0;
    case (state)
      FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        irWriteRaw = memDone;
        pcWriteRaw = memDone;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      MEMWB: begin
        MemtoReg    = 1'b1;
        regWriteRaw = 1'b1;
      end
      MEMWR: begin
        IorD        = 1'b1;
        memWriteRaw = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegDst      = 1'b1;
        regWriteRaw = 1'b1;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSrc    = 2'b01;
        Branch   = (OpCode == OP_BEQ);
        BranchNe = (OpCode == OP_BNE) && (ENABLE_BNE != 0);
      end
      IMMEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (OpCode == OP_ADDI) ? 2'b00 : 2'b11;
      end
      IMMWB: regWriteRaw = 1'b1;
      JUMP: begin
        PCSrc      = 2'b10;
        pcWriteRaw = 1'b1;
      end
      ERROR: begin
        illegalRaw  = ~errIsMem;
        memErrorRaw = errIsMem;
      end
      default: begin
        IorD = 1'b0;
      end
    endcase
  end

  assign IRWrite   = irWriteRaw  & ~reset;
  assign PCWrite   = pcWriteRaw  & ~reset;
  assign RegWrite  = regWriteRaw & ~reset;
  assign MemWrite  = memWriteRaw & ~reset;
  assign IllegalOp = illegalRaw  & ~reset;
  assign MemError  = memErrorRaw & ~reset;
  assign State     = state;

endmodule
